spi_cmd_responder: RTL and testbench

//  Responder side of the 34-bit command port (adr/cmd_stb/cmd_word) driven by the FIFO command sequencers.

---
 rtl/spi_cmd_pkg.sv | 36 +++
 rtl/spi_cmd_clkgen.sv | 40 ++++
 rtl/spi_cmd_responder.sv | 179 +++++++++++++++++
 tb/tb_spi_cmd_responder.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command responder: register map, CTRL bit layout, FSM states.
// Optional loopback (CTRL[14]) is enabled in the top by defining SPI_LOOPBACK_EN.
package spi_cmd_pkg;

  localparam int unsigned CMD_W      = 34;
  localparam int unsigned CMD_RD_BIT = 33;
  localparam int unsigned CMD_WR_BIT = 32;

  localparam logic [7:0] ADR_TXRX   = 8'h00;
  localparam logic [7:0] ADR_CTRL   = 8'h10;
  localparam logic [7:0] ADR_DIVIDE = 8'h14;
  localparam logic [7:0] ADR_SS     = 8'h18;

  localparam int unsigned CTRL_W      = 15;
  localparam int unsigned CTRL_GO     = 8;
  localparam int unsigned CTRL_RX_NEG = 9;
  localparam int unsigned CTRL_TX_NEG = 10;
  localparam int unsigned CTRL_LSB    = 11;
  localparam int unsigned CTRL_IE     = 12;
  localparam int unsigned CTRL_ASS    = 13;
  localparam int unsigned CTRL_LOOP   = 14;

  typedef enum logic [1:0] {StIdle, StLoad, StShift, StDone} spi_state_e;

  // CHAR_LEN of 0 means a full word; out-of-range lengths are clamped to 32 as well.
  function automatic logic [5:0] char_bits(input logic [5:0] len);
    return (len == 6'd0 || len > 6'd32) ? 6'd32 : len;
  endfunction

  // Position within the word of the cnt-th bit on the wire (len of 32 encodes as 0 here).
  function automatic logic [4:0] bit_index(input logic [4:0] cnt, input logic [4:0] len,
                                           input logic lsb);
    return lsb ? cnt : (len - 5'd1 - cnt);
  endfunction

endpackage

// File: rtl/spi_cmd_clkgen.sv
// SCLK generator: toggles sclk every DIVIDE+1 enabled cycles and flags which edge is being made.
module spi_cmd_clkgen
  import spi_cmd_pkg::*;
#(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_divide,
  output logic             o_sclk,
  output logic             o_pos,
  output logic             o_neg
);

  logic [DIV_W-1:0] r_cnt;
  logic             r_sclk;
  logic             w_tick;

  assign w_tick = i_en && (r_cnt == i_divide);
  assign o_pos  = w_tick && !r_sclk;
  assign o_neg  = w_tick && r_sclk;
  assign o_sclk = r_sclk;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt  <= '0;
      r_sclk <= 1'b0;
    end else if (i_en) begin
      if (w_tick) begin
        r_cnt  <= '0;
        r_sclk <= !r_sclk;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_cmd_responder.sv
// Command-port register file plus SPI master shifter driven by the FIFO command sequencers.
// Define SPI_LOOPBACK_EN to enable CTRL[14] LOOP (receiver fed from mosi instead of miso).
module spi_cmd_responder
  import spi_cmd_pkg::*;
#(
  parameter int unsigned SS_W  = 8,
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       adr,
  input  logic [CMD_W-1:0] cmd_word,
  input  logic             cmd_stb,
  output logic [31:0]      rd_data,
  output logic             rd_valid,
  output logic             int_o,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic [SS_W-1:0]  ss_n
);

`ifdef SPI_LOOPBACK_EN
  localparam logic [CTRL_W-1:0] CtrlMask = 15'h7F3F;
`else
  localparam logic [CTRL_W-1:0] CtrlMask = 15'h7F3F & ~(15'(1) << CTRL_LOOP);
`endif

  spi_state_e        r_state, w_state_next;
  logic              r_stb_prev;
  logic [CTRL_W-1:0] r_ctrl;
  logic [DIV_W-1:0]  r_divide;
  logic [SS_W-1:0]   r_ss;
  logic [31:0]       r_tx, r_rx, r_rx_sh, r_rd_data;
  logic              r_rd_valid, r_int, r_mosi;
  logic [5:0]        r_tx_cnt, r_rx_cnt;
  logic [6:0]        r_edge_cnt;

  logic              w_accept, w_wr_ok, w_rd, w_go_start;
  logic              w_load, w_shift, w_done;
  logic              w_pos, w_neg, w_tx_edge, w_rx_edge, w_rx_din;
  logic [5:0]        w_len;
  logic [6:0]        w_edges_m1;
  logic [4:0]        w_first_idx, w_tx_idx, w_rx_idx;
  logic [31:0]       w_rd_mux;

  assign w_accept   = cmd_stb && !r_stb_prev;
  assign w_wr_ok    = w_accept && cmd_word[CMD_WR_BIT] && (r_state == StIdle);
  assign w_rd       = w_accept && cmd_word[CMD_RD_BIT] && !cmd_word[CMD_WR_BIT];
  assign w_go_start = w_wr_ok && (adr == ADR_CTRL) && cmd_word[CTRL_GO];

  assign w_len       = char_bits(r_ctrl[5:0]);
  assign w_edges_m1  = {w_len, 1'b0} - 7'd1;
  assign w_first_idx = bit_index(5'd0, w_len[4:0], r_ctrl[CTRL_LSB]);
  assign w_tx_idx    = bit_index(r_tx_cnt[4:0], w_len[4:0], r_ctrl[CTRL_LSB]);
  assign w_rx_idx    = bit_index(r_rx_cnt[4:0], w_len[4:0], r_ctrl[CTRL_LSB]);
  assign w_tx_edge   = r_ctrl[CTRL_TX_NEG] ? w_pos : w_neg;
  assign w_rx_edge   = r_ctrl[CTRL_RX_NEG] ? w_neg : w_pos;

`ifdef SPI_LOOPBACK_EN
  assign w_rx_din = r_ctrl[CTRL_LOOP] ? r_mosi : miso;
`else
  assign w_rx_din = miso;
`endif

  spi_cmd_clkgen #(
    .DIV_W(DIV_W)
  ) u_clkgen (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_load),
    .i_en    (w_shift),
    .i_divide(r_divide),
    .o_sclk  (sclk),
    .o_pos   (w_pos),
    .o_neg   (w_neg)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= StIdle;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_go_start) w_state_next = StLoad;
      StLoad:  w_state_next = StShift;
      StShift: if ((w_pos || w_neg) && (r_edge_cnt == w_edges_m1)) w_state_next = StDone;
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_load  = (r_state == StLoad);
    w_shift = (r_state == StShift);
    w_done  = (r_state == StDone);
    if (r_ctrl[CTRL_ASS] && !(w_load || w_shift)) ss_n = '1;
    else                                          ss_n = ~r_ss;
  end

  always_comb begin
    w_rd_mux = '0;
    case (adr)
      ADR_TXRX:   w_rd_mux = r_rx;
      ADR_CTRL:   w_rd_mux = 32'(r_ctrl);
      ADR_DIVIDE: w_rd_mux = 32'(r_divide);
      ADR_SS:     w_rd_mux = 32'(r_ss);
      default:    w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stb_prev <= 1'b0;
      r_ctrl     <= '0;
      r_divide   <= '0;
      r_ss       <= '0;
      r_tx       <= '0;
      r_rx       <= '0;
      r_rx_sh    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_int      <= 1'b0;
      r_mosi     <= 1'b0;
      r_tx_cnt   <= '0;
      r_rx_cnt   <= '0;
      r_edge_cnt <= '0;
    end else begin
      r_stb_prev <= cmd_stb;
      r_rd_valid <= 1'b0;
      if (w_accept) r_int <= 1'b0;
      if (w_wr_ok) begin
        case (adr)
          ADR_TXRX:   r_tx     <= cmd_word[31:0];
          ADR_CTRL:   r_ctrl   <= cmd_word[CTRL_W-1:0] & CtrlMask;
          ADR_DIVIDE: r_divide <= cmd_word[DIV_W-1:0];
          ADR_SS:     r_ss     <= cmd_word[SS_W-1:0];
          default:    ;
        endcase
      end
      if (w_rd) begin
        r_rd_valid <= 1'b1;
        r_rd_data  <= w_rd_mux;
      end
      if (w_load) begin
        r_rx_sh    <= '0;
        r_mosi     <= r_tx[w_first_idx];
        r_tx_cnt   <= 6'd1;
        r_rx_cnt   <= '0;
        r_edge_cnt <= '0;
      end
      if (w_shift && (w_pos || w_neg)) begin
        r_edge_cnt <= r_edge_cnt + 7'd1;
        // Counters stop at the word length so trailing edges shift nothing.
        if (w_tx_edge && (r_tx_cnt < w_len)) begin
          r_mosi   <= r_tx[w_tx_idx];
          r_tx_cnt <= r_tx_cnt + 6'd1;
        end
        if (w_rx_edge && (r_rx_cnt < w_len)) begin
          r_rx_sh[w_rx_idx] <= w_rx_din;
          r_rx_cnt          <= r_rx_cnt + 6'd1;
        end
      end
      if (w_done) begin
        r_rx            <= r_rx_sh;
        r_ctrl[CTRL_GO] <= 1'b0;
        r_int           <= r_ctrl[CTRL_IE];
      end
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign int_o    = r_int;
  assign mosi     = r_mosi;

endmodule

// File: tb/tb_spi_cmd_responder.sv
// Self-checking bench for spi_cmd_responder: directed scenarios plus randomized transfers
// checked against a word-level model of the wire order, received data and transfer latency.
module tb_spi_cmd_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  adr;
  logic [33:0] cmd_word;
  logic        cmd_stb;
  logic [31:0] rd_data;
  logic        rd_valid, int_o, sclk, mosi, miso;
  logic [7:0]  ss_n;

  int errors = 0;
  int checks = 0;

  bit          mon_en = 1'b0;
  logic        mosi_q[$];
  int          ss_viol, sclk_hi;
  logic [31:0] miso_word;
  int          miso_n, miso_idx;
  bit          miso_lsb;

  spi_cmd_responder #(
    .SS_W (8),
    .DIV_W(16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .adr     (adr),
    .cmd_word(cmd_word),
    .cmd_stb (cmd_stb),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .int_o   (int_o),
    .sclk    (sclk),
    .mosi    (mosi),
    .miso    (miso),
    .ss_n    (ss_n)
  );

  always #5 clk = ~clk;

  // Word position of the i-th bit on the wire.
  function automatic int bpos(input int i, input int n, input bit lsb);
    return lsb ? i : n - 1 - i;
  endfunction

  function automatic logic [31:0] wire_order(input logic [31:0] v, input int n, input bit lsb);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = v[bpos(i, n, lsb)];
    return r;
  endfunction

  function automatic logic [31:0] low_mask(input int n);
    return (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
  endfunction

  function automatic logic [31:0] captured();
    logic [31:0] r;
    r = '0;
    foreach (mosi_q[i]) if (i < 32) r[i] = mosi_q[i];
    return r;
  endfunction

  // Slave model: sample mosi on rising sclk, present the next miso bit after falling sclk.
  always @(posedge sclk) if (mon_en) begin
    mosi_q.push_back(mosi);
    if (ss_n[0] !== 1'b0) ss_viol++;
  end

  always @(negedge sclk) if (mon_en) begin
    miso_idx++;
    if (miso_idx < miso_n) miso = miso_word[bpos(miso_idx, miso_n, miso_lsb)];
  end

  always @(negedge clk) if (mon_en && sclk === 1'b1) sclk_hi++;

  task automatic send(input logic [7:0] a, input logic rd, input logic wr, input logic [31:0] d,
                      input int hold);
    adr      = a;
    cmd_word = {rd, wr, d};
    cmd_stb  = 1'b1;
    repeat (hold) @(negedge clk);
    cmd_stb = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_reg(input logic [7:0] a, output logic [31:0] d, output int pulses);
    adr      = a;
    cmd_word = {2'b10, 32'h0};
    cmd_stb  = 1'b1;
    pulses   = 0;
    d        = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) cmd_stb = 1'b0;
      if (rd_valid === 1'b1) begin
        pulses++;
        d = rd_data;
      end
    end
  endtask

  task automatic arm(input logic [31:0] mw, input int n, input bit lsb);
    mosi_q.delete();
    ss_viol   = 0;
    sclk_hi   = 0;
    miso_word = mw;
    miso_n    = n;
    miso_lsb  = lsb;
    miso_idx  = 0;
    miso      = mw[bpos(0, n, lsb)];
    mon_en    = 1'b1;
  endtask

  // Writes CTRL (with GO) and counts clock edges from the accept edge until int_o is seen.
  task automatic run_xfer(input logic [31:0] ctrl, output int lat);
    adr      = 8'h10;
    cmd_word = {2'b01, ctrl};
    cmd_stb  = 1'b1;
    @(posedge clk);
    lat = 0;
    @(negedge clk);
    cmd_stb = 1'b0;
    while (int_o !== 1'b1 && lat < 5000) begin
      @(negedge clk);
      lat++;
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int p;
    rst = 1'b1; adr = '0; cmd_word = '0; cmd_stb = 1'b0; miso = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (rd_data !== 32'h0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got=%b exp=0", rd_valid); end
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL reset_int got=%b exp=0", int_o); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got=%b exp=0", mosi); end
    checks++; if (ss_n !== 8'hFF) begin errors++; $display("FAIL reset_ss_n got=%h exp=ff", ss_n); end
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", d); end
    rd_reg(8'h44, d, p);
    checks++; if (d !== 32'h0 || p !== 1) begin errors++; $display("FAIL unknown_adr_read got=%h/%0d exp=0/1", d, p); end
  endtask

  task automatic test_init();
    logic [31:0] d;
    int p;
    send(8'h14, 1'b0, 1'b1, 32'h0, 2);
    send(8'h10, 1'b0, 1'b1, 32'h3010, 2);
    send(8'h18, 1'b0, 1'b1, 32'h1, 2);
    rd_reg(8'h14, d, p);
    checks++; if (d !== 32'h0 || p !== 1) begin errors++; $display("FAIL init_divide got=%h/%0d exp=0/1", d, p); end
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h3010 || p !== 1) begin errors++; $display("FAIL init_ctrl got=%h/%0d exp=3010/1", d, p); end
    rd_reg(8'h18, d, p);
    checks++; if (d !== 32'h1 || p !== 1) begin errors++; $display("FAIL init_ss got=%h/%0d exp=1/1", d, p); end
    checks++; if (ss_n !== 8'hFF) begin errors++; $display("FAIL init_ss_idle got=%h exp=ff", ss_n); end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    int p, lat;
    send(8'h00, 1'b0, 1'b1, 32'h1234, 1);
    arm(32'hA5C3, 16, 1'b0);
    run_xfer(32'h3110, lat);
    checks++; if (lat !== 34) begin errors++; $display("FAIL basic_latency got=%0d exp=34", lat); end
    checks++; if (mosi_q.size() !== 16) begin errors++; $display("FAIL basic_pulses got=%0d exp=16", mosi_q.size()); end
    checks++; if (captured() !== wire_order(32'h1234, 16, 1'b0)) begin
      errors++; $display("FAIL basic_mosi got=%h exp=%h", captured(), wire_order(32'h1234, 16, 1'b0)); end
    checks++; if (ss_viol !== 0) begin errors++; $display("FAIL basic_ss_during got=%0d exp=0", ss_viol); end
    checks++; if (ss_n !== 8'hFF || sclk !== 1'b0) begin
      errors++; $display("FAIL basic_idle_pins got=%h/%b exp=ff/0", ss_n, sclk); end
    rd_reg(8'h00, d, p);
    checks++; if (d !== 32'h0000A5C3) begin errors++; $display("FAIL basic_rx got=%h exp=0000a5c3", d); end
    checks++; if (p !== 1) begin errors++; $display("FAIL basic_rd_valid got=%0d exp=1", p); end
  endtask

  task automatic test_lsb_div();
    int lat;
    send(8'h14, 1'b0, 1'b1, 32'h3, 1);
    send(8'h00, 1'b0, 1'b1, 32'h81, 1);
    arm(32'h0, 8, 1'b1);
    run_xfer(32'h3908, lat);
    checks++; if (lat !== 66) begin errors++; $display("FAIL lsb_latency got=%0d exp=66", lat); end
    checks++; if (captured() !== 32'h81 || mosi_q.size() !== 8) begin
      errors++; $display("FAIL lsb_mosi got=%h/%0d exp=81/8", captured(), mosi_q.size()); end
    checks++; if (sclk_hi !== 32) begin errors++; $display("FAIL lsb_sclk_high got=%0d exp=32", sclk_hi); end
  endtask

  task automatic test_busy();
    logic [31:0] d;
    int p, w, lat;
    send(8'h14, 1'b0, 1'b1, 32'h1, 1);
    send(8'h00, 1'b0, 1'b1, 32'hC3, 1);
    arm(32'h0, 8, 1'b0);
    adr = 8'h10; cmd_word = {2'b01, 32'h3108}; cmd_stb = 1'b1;
    @(negedge clk);
    cmd_stb = 1'b0;
    @(negedge clk);
    send(8'h00, 1'b0, 1'b1, 32'hFFFF, 1);
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h3108) begin errors++; $display("FAIL busy_ctrl_go got=%h exp=3108", d); end
    w = 0;
    while (int_o !== 1'b1 && w < 2000) begin @(negedge clk); w++; end
    mon_en = 1'b0;
    checks++; if (int_o !== 1'b1) begin errors++; $display("FAIL busy_int got=%b exp=1", int_o); end
    checks++; if (captured() !== wire_order(32'hC3, 8, 1'b0)) begin
      errors++; $display("FAIL busy_mosi1 got=%h exp=%h", captured(), wire_order(32'hC3, 8, 1'b0)); end
    rd_reg(8'h18, d, p);
    checks++; if (int_o !== 1'b0) begin errors++; $display("FAIL int_clear got=%b exp=0", int_o); end
    arm(32'h0, 8, 1'b0);
    run_xfer(32'h3108, lat);
    checks++; if (captured() !== wire_order(32'hC3, 8, 1'b0)) begin
      errors++; $display("FAIL busy_mosi2 got=%h exp=%h", captured(), wire_order(32'hC3, 8, 1'b0)); end
    checks++; if (lat !== 34) begin errors++; $display("FAIL busy_latency got=%0d exp=34", lat); end
  endtask

  task automatic test_random();
    logic [31:0] tx, mw, ctrl, d;
    int n, dv, p, lat;
    bit lsb;
    for (int it = 0; it < 10; it++) begin
      n   = $urandom_range(32, 1);
      dv  = $urandom_range(3, 0);
      lsb = 1'($urandom_range(1, 0));
      tx  = $urandom;
      mw  = $urandom;
      send(8'h14, 1'b0, 1'b1, 32'(dv), 1);
      send(8'h00, 1'b0, 1'b1, tx, 1);
      ctrl = 32'h3100 | (32'(lsb) << 11) | ((n == 32) ? 32'h0 : 32'(n));
      arm(mw, n, lsb);
      run_xfer(ctrl, lat);
      checks++; if (lat !== 2 * n * (dv + 1) + 2) begin
        errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", it, lat, 2 * n * (dv + 1) + 2); end
      checks++; if (mosi_q.size() !== n || captured() !== wire_order(tx, n, lsb)) begin
        errors++; $display("FAIL rnd%0d_mosi got=%h/%0d exp=%h/%0d", it, captured(), mosi_q.size(),
                           wire_order(tx, n, lsb), n); end
      checks++; if (sclk_hi !== n * (dv + 1)) begin
        errors++; $display("FAIL rnd%0d_sclk_high got=%0d exp=%0d", it, sclk_hi, n * (dv + 1)); end
      checks++; if (ss_viol !== 0) begin errors++; $display("FAIL rnd%0d_ss got=%0d exp=0", it, ss_viol); end
      rd_reg(8'h00, d, p);
      checks++; if (d !== (mw & low_mask(n))) begin
        errors++; $display("FAIL rnd%0d_rx got=%h exp=%h", it, d, mw & low_mask(n)); end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    int p;
    send(8'h14, 1'b0, 1'b1, 32'h3, 1);
    mon_en = 1'b0;
    adr = 8'h10; cmd_word = {2'b01, 32'h3110}; cmd_stb = 1'b1;
    @(negedge clk);
    cmd_stb = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (ss_n[0] !== 1'b0) begin errors++; $display("FAIL mid_ss_active got=%b exp=0", ss_n[0]); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if (sclk !== 1'b0 || ss_n !== 8'hFF || int_o !== 1'b0) begin
      errors++; $display("FAIL mid_reset_pins got=%b/%h/%b exp=0/ff/0", sclk, ss_n, int_o); end
    rst = 1'b0;
    repeat (300) @(negedge clk);
    checks++; if (int_o !== 1'b0 || sclk !== 1'b0) begin
      errors++; $display("FAIL mid_no_int got=%b/%b exp=0/0", int_o, sclk); end
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL mid_ctrl got=%h exp=0", d); end
  endtask

  task automatic test_loopback();
    logic [31:0] d, tx;
    int p, lat;
    send(8'h14, 1'b0, 1'b1, 32'h0, 1);
    send(8'h18, 1'b0, 1'b1, 32'h1, 1);
    tx = $urandom;
`ifdef SPI_LOOPBACK_EN
    send(8'h00, 1'b0, 1'b1, tx, 1);
    mon_en = 1'b0;
    miso   = ~tx[15];
    run_xfer(32'h7110, lat);
    rd_reg(8'h00, d, p);
    checks++; if (d !== {16'h0, tx[15:0]}) begin errors++; $display("FAIL loop_rx got=%h exp=%h", d, {16'h0, tx[15:0]}); end
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h7010) begin errors++; $display("FAIL loop_ctrl got=%h exp=7010", d); end
`else
    send(8'h10, 1'b0, 1'b1, 32'h7010, 1);
    rd_reg(8'h10, d, p);
    checks++; if (d !== 32'h3010) begin errors++; $display("FAIL noloop_ctrl got=%h exp=3010", d); end
    send(8'h00, 1'b0, 1'b1, tx, 1);
    arm(~tx, 16, 1'b0);
    run_xfer(32'h7110, lat);
    rd_reg(8'h00, d, p);
    checks++; if (d !== {16'h0, ~tx[15:0]}) begin errors++; $display("FAIL noloop_rx got=%h exp=%h", d, {16'h0, ~tx[15:0]}); end
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_lsb_div();
    test_busy();
    test_random();
    test_reset_mid();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
